sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO buffer for intra-domain buffering between pipeline stages and peripherals, running in a single clock domain. It generalises the project's dual-clock FIFO with:
- a selectable output mode: registered read or first-word-fall-through (FWFT);
- an exact occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a synchronous flush.

## Interface
Parameters:
- DW, 32: data width in bits, ≥1.
- DP, 64: depth in entries; power of two, ≥4. ADDRW = log2(DP).
- AFULL_TH, DP-4: almost_full asserts when count ≥ AFULL_TH; legal range 1..DP.
- AEMPTY_TH, 4: almost_empty asserts when count ≤ AEMPTY_TH; legal range 0..DP-1.
- FWFT, 0: 0 = registered read output, 1 = first-word-fall-through.

Ports:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, count and error flags.
- w_req  in  1  write request.
- data_i  in  DW  write data.
- full  out  1  count == DP.
- r_req  in  1  read request.
- data_o  out  DW  read data.
- empty  out  1  count == 0.
- count  out  ADDRW+1  current occupancy, 0..DP.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DP×DW register array, indexed by the low ADDRW bits of ADDRW+1-bit binary pointers w_ptr and r_ptr. The MSB is the wrap bit.
- count = w_ptr − r_ptr, modulo 2^(ADDRW+1).
- Write accept (wa) = w_req & ~full & ~flush. Writes mem[w_ptr] and increments w_ptr.
- Read accept (ra) = r_req & ~empty & ~flush. Increments r_ptr.
- Acceptance uses the pre-edge flags only:
  - full with w_req & r_req: the read is accepted, the write is rejected, and overflow sets.
  - empty with w_req & r_req: the write is accepted, the read is rejected, and underflow sets.
- Error flags:
  - overflow sets on w_req & full & ~flush.
  - underflow sets on r_req & empty & ~flush.
  - Both hold until flush or reset.
- Read data, FWFT=0: on ra, data_o <= mem[r_ptr] at the clock edge. data_o holds its value otherwise, including while empty.
- Read data, FWFT=1: data_o = mem[r_ptr[ADDRW-1:0]] combinationally. It is valid whenever empty=0 and undefined-but-stable when empty=1. r_req acts as the pop/acknowledge.
- flush:
  - Takes priority over w_req and r_req, which are both ignored in that cycle.
  - Next cycle: w_ptr = r_ptr = 0, count = 0, overflow = underflow = 0.
  - The array contents are not cleared.
  - With FWFT=0, data_o is cleared to 0.
- Pointer wrap is natural modular arithmetic. There is no special casing at DP−1 → 0; only the wrap bit distinguishes full from empty.
- Status outputs (full, empty, count, almost_*) are decoded combinationally from the registered pointers. They never depend combinationally on w_req or r_req.

## Timing
- Reset values: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, data_o = 0 (FWFT=0). Reset takes effect immediately on rst_n low, regardless of clock. Reset mid-operation discards all contents.
- Write to an empty FIFO: empty falls 1 cycle after the accepting edge.
  - FWFT=1: data_o shows the word in that same cycle.
  - FWFT=0: the first r_req is accepted in that cycle, and data_o is valid 1 cycle after it.
- Read latency: FWFT=1 has 0 cycles (data present before the pop); FWFT=0 has 1 cycle.
- Status flags update 1 cycle after the accepting edge.
- Simultaneous wa & ra: count is unchanged, and full, empty and almost_* do not toggle.
- Throughput: 1 write and 1 read per cycle, sustained.

## Test plan
- Reset, then write 0x1..0x40 with DP=64 and no reads → full=1 after the 64th edge, count=64, almost_full from count=60. A 65th write sets overflow=1, and contents stay unchanged.
- Drain the full FIFO with FWFT=0 → data_o sequence 0x1..0x40, each 1 cycle after its r_req. empty=1 after the last read, almost_empty from count=4. An extra read sets underflow=1, and data_o holds 0x40.
- FWFT=1: a single write of 0xA5 to an empty FIFO → next cycle empty=0 and data_o=0xA5 with no r_req. Pop → empty=1.
- Continuous simultaneous w_req & r_req at count=10 for 200 cycles → count stays at 10, pointers wrap at least 3 times, and the data order is preserved.
- w_req & r_req while full → the read is accepted, count becomes 63, overflow=1. Repeat at empty → the write is accepted, count becomes 1, underflow=1.
- flush asserted together with w_req & r_req at count=30 with both error flags set → next cycle count=0, empty=1, overflow = underflow = 0, and the request in the flush cycle is ignored. Also check that rst_n low mid-burst restores all reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read
// output, exact occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
//
// Storage is a DP x DW register array addressed by the low ADDRW bits of two
// (ADDRW+1)-bit binary pointers. The extra MSB is a wrap bit, so occupancy is
// simply the modular difference of the pointers and full/empty are told apart
// without any special casing at the DP-1 -> 0 boundary.
module sync_fifo #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DP        = 64,
  parameter int unsigned AFULL_TH  = DP - 4,
  parameter int unsigned AEMPTY_TH = 4,
  parameter bit          FWFT      = 1'b0,
  localparam int unsigned ADDRW    = $clog2(DP)
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             w_req,
  input  logic [DW-1:0]    data_i,
  output logic             full,
  input  logic             r_req,
  output logic [DW-1:0]    data_o,
  output logic             empty,
  output logic [ADDRW:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  // Thresholds resized once to the count width so every compare is same-width.
  localparam logic [ADDRW:0] FullCnt   = (ADDRW + 1)'(DP);
  localparam logic [ADDRW:0] AfullCnt  = (ADDRW + 1)'(AFULL_TH);
  localparam logic [ADDRW:0] AemptyCnt = (ADDRW + 1)'(AEMPTY_TH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDRW:0]  w_ptr_q, w_ptr_d;
  logic [ADDRW:0]  r_ptr_q, r_ptr_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic [DW-1:0]   mem_q [DP];

  // ---------------------------------------------------------------------------
  // Status decode: purely from the registered pointers, never from requests
  // ---------------------------------------------------------------------------
  logic [ADDRW:0]  count_w;
  logic            full_w;
  logic            empty_w;

  // Occupancy and flags decoded from the pointer difference.
  always_comb begin
    count_w = w_ptr_q - r_ptr_q;
    full_w  = (count_w == FullCnt);
    empty_w = (count_w == '0);
  end

  assign count        = count_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_w >= AfullCnt);
  assign almost_empty = (count_w <= AemptyCnt);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // ---------------------------------------------------------------------------
  // Request acceptance
  // ---------------------------------------------------------------------------
  // Acceptance looks only at the pre-edge flags: a write into a full FIFO is
  // refused even if a read frees a slot in the same cycle, and vice versa.
  logic wa;
  logic ra;

  // Accept decode; flush masks both requests.
  always_comb begin
    wa = w_req & ~full_w  & ~flush;
    ra = r_req & ~empty_w & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Pointer advance and sticky error flags; flush clears all of them.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      w_ptr_d = w_ptr_q + {{ADDRW{1'b0}}, wa};
      r_ptr_d = r_ptr_q + {{ADDRW{1'b0}}, ra};
      ovf_d   = ovf_q | (w_req & full_w);
      udf_d   = udf_q | (r_req & empty_w);
    end
  end

  // Pointer and flag registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // Array is intentionally not reset or flushed; the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wa) begin
      mem_q[w_ptr_q[ADDRW-1:0]] <= data_i;
    end
  end

  logic [DW-1:0] rd_data;
  assign rd_data = mem_q[r_ptr_q[ADDRW-1:0]];

  // ---------------------------------------------------------------------------
  // Read data output
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_fwft
    // Head of queue is presented directly; r_req only acknowledges it.
    assign data_o = rd_data;
  end else begin : g_reg
    logic [DW-1:0] dout_q, dout_d;

    // Capture the head word on an accepted read, hold otherwise.
    always_comb begin
      dout_d = dout_q;
      if (flush) begin
        dout_d = '0;
      end else if (ra) begin
        dout_d = rd_data;
      end
    end

    // Registered read data with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign data_o = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo. One registered-output and one FWFT
// instance share the same stimulus and are compared against a queue-based
// reference model after every clock.
module tb_sync_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 64;
  localparam int unsigned AF = DP - 4;
  localparam int unsigned AE = 4;

  logic          clk_i;
  logic          rst_n;
  logic          flush;
  logic          w_req;
  logic          r_req;
  logic [DW-1:0] data_i;

  logic          full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
  logic [6:0]    count_r;
  logic [DW-1:0] dout_r;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [6:0]    count_f;
  logic [DW-1:0] dout_f;

  int n_total;
  int n_bad;

  // Reference model state.
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] m_dout;

  sync_fifo #(
    .DW(DW), .DP(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b0)
  ) u_dut_reg (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush       (flush),
    .w_req       (w_req),
    .data_i      (data_i),
    .full        (full_r),
    .r_req       (r_req),
    .data_o      (dout_r),
    .empty       (empty_r),
    .count       (count_r),
    .almost_full (af_r),
    .almost_empty(ae_r),
    .overflow    (ovf_r),
    .underflow   (udf_r)
  );

  sync_fifo #(
    .DW(DW), .DP(DP), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b1)
  ) u_dut_fwft (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush       (flush),
    .w_req       (w_req),
    .data_i      (data_i),
    .full        (full_f),
    .r_req       (r_req),
    .data_o      (dout_f),
    .empty       (empty_f),
    .count       (count_f),
    .almost_full (af_f),
    .almost_empty(ae_f),
    .overflow    (ovf_f),
    .underflow   (udf_f)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  // Applies one clock edge worth of behaviour using the pre-edge occupancy.
  task automatic model_update(input logic w, input logic r, input logic f,
                              input logic [DW-1:0] d);
    int sz = q.size();
    if (f) begin
      model_reset();
    end else begin
      if (w && sz == DP) m_ovf = 1'b1;
      if (r && sz == 0)  m_udf = 1'b1;
      if (r && sz > 0)   m_dout = q.pop_front();
      if (w && sz < DP)  q.push_back(d);
    end
  endtask

  task automatic check_all(input string ph);
    int sz = q.size();
    check_eq({ph, ".reg.count"}, 64'(count_r), 64'(sz));
    check_eq({ph, ".reg.empty"}, 64'(empty_r), 64'(sz == 0));
    check_eq({ph, ".reg.full"},  64'(full_r),  64'(sz == DP));
    check_eq({ph, ".reg.afull"}, 64'(af_r),    64'(sz >= AF));
    check_eq({ph, ".reg.aempty"}, 64'(ae_r),   64'(sz <= AE));
    check_eq({ph, ".reg.ovf"},   64'(ovf_r),   64'(m_ovf));
    check_eq({ph, ".reg.udf"},   64'(udf_r),   64'(m_udf));
    check_eq({ph, ".reg.data"},  64'(dout_r),  64'(m_dout));
    check_eq({ph, ".fwft.count"}, 64'(count_f), 64'(sz));
    check_eq({ph, ".fwft.empty"}, 64'(empty_f), 64'(sz == 0));
    check_eq({ph, ".fwft.full"},  64'(full_f),  64'(sz == DP));
    check_eq({ph, ".fwft.afull"}, 64'(af_f),    64'(sz >= AF));
    check_eq({ph, ".fwft.aempty"}, 64'(ae_f),   64'(sz <= AE));
    check_eq({ph, ".fwft.ovf"},   64'(ovf_f),   64'(m_ovf));
    check_eq({ph, ".fwft.udf"},   64'(udf_f),   64'(m_udf));
    if (sz > 0) check_eq({ph, ".fwft.data"}, 64'(dout_f), 64'(q[0]));
  endtask

  // Called at posedge+1: drive, take one edge, update model, sample at +1.
  task automatic step(input string ph, input logic w, input logic r, input logic f,
                      input logic [DW-1:0] d);
    w_req  = w;
    r_req  = r;
    flush  = f;
    data_i = d;
    @(posedge clk_i);
    model_update(w, r, f, d);
    #1;
    w_req = 1'b0;
    r_req = 1'b0;
    flush = 1'b0;
    check_all(ph);
  endtask

  initial begin
    int wp;
    int rp;
    n_total = 0;
    n_bad   = 0;
    flush   = 1'b0;
    w_req   = 1'b0;
    r_req   = 1'b0;
    data_i  = '0;
    model_reset();
    rst_n   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check_all("rst");
    check_eq("rst.empty_const", 64'(empty_r), 64'd1);
    check_eq("rst.aempty_const", 64'(ae_f), 64'd1);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("idle");

    // Fill 0x1..0x40, then one rejected write.
    for (int i = 1; i <= 64; i++) step("fill", 1'b1, 1'b0, 1'b0, DW'(i));
    check_eq("fill.count_const", 64'(count_r), 64'd64);
    step("ovf", 1'b1, 1'b0, 1'b0, 32'hdead_beef);
    check_eq("ovf.flag_const", 64'(ovf_r), 64'd1);

    // Drain in order, then one rejected read.
    for (int i = 1; i <= 64; i++) begin
      if (i > 1) check_eq("drain.fwft_head", 64'(dout_f), 64'(i));
      step("drain", 1'b0, 1'b1, 1'b0, '0);
      check_eq("drain.reg_data", 64'(dout_r), 64'(i));
    end
    step("udf", 1'b0, 1'b1, 1'b0, '0);
    check_eq("udf.hold_data", 64'(dout_r), 64'h40);
    check_eq("udf.flag_const", 64'(udf_r), 64'd1);

    // Single FWFT write shows up without a pop.
    step("flush1", 1'b0, 1'b0, 1'b1, '0);
    step("a5.wr", 1'b1, 1'b0, 1'b0, 32'h0000_00a5);
    check_eq("a5.fwft_data", 64'(dout_f), 64'ha5);
    check_eq("a5.empty", 64'(empty_f), 64'd0);
    step("a5.pop", 1'b0, 1'b1, 1'b0, '0);
    check_eq("a5.empty_after", 64'(empty_f), 64'd1);

    // Sustained simultaneous traffic at count=10; pointers wrap several times.
    for (int i = 0; i < 10; i++) step("c10.fill", 1'b1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 200; i++) step("c10.rw", 1'b1, 1'b1, 1'b0, $urandom);
    check_eq("c10.count_const", 64'(count_r), 64'd10);

    // Write+read while full, then while empty.
    step("flush2", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 64; i++) step("full.fill", 1'b1, 1'b0, 1'b0, $urandom);
    step("full.rw", 1'b1, 1'b1, 1'b0, $urandom);
    check_eq("full.rw_count", 64'(count_r), 64'd63);
    step("flush3", 1'b0, 1'b0, 1'b1, '0);
    step("empty.rw", 1'b1, 1'b1, 1'b0, $urandom);
    check_eq("empty.rw_count", 64'(count_r), 64'd1);

    // Flush with requests at count=30 and both sticky flags set.
    step("flush4", 1'b0, 1'b0, 1'b1, '0);
    step("fl.udf", 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 65; i++) step("fl.fill", 1'b1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 34; i++) step("fl.read", 1'b0, 1'b1, 1'b0, '0);
    check_eq("fl.pre_count", 64'(count_r), 64'd30);
    step("fl.flush", 1'b1, 1'b1, 1'b1, $urandom);
    check_eq("fl.count_const", 64'(count_r), 64'd0);
    check_eq("fl.ovf_const", 64'(ovf_r), 64'd0);

    // Randomised traffic with alternating bias so both ends are reached.
    for (int i = 0; i < 1600; i++) begin
      wp = ((i / 150) % 2 == 0) ? 80 : 25;
      rp = ((i / 150) % 2 == 0) ? 25 : 80;
      step("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 299) == 0, $urandom);
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 20; i++) step("burst", 1'b1, 1'b0, 1'b0, $urandom);
    w_req  = 1'b1;
    data_i = $urandom;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    w_req = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    check_all("arst.idle");
    for (int i = 0; i < 8; i++) step("post", 1'b1, i[0], 1'b0, $urandom);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
